df_start_chan_fifo: RTL and testbench

//  Start-token channel between two dataflow processes (producer writes a start token, consumer pops it on launch).

---
 rtl/df_start_chan_fifo.sv | 141 ++++++++++++++
 tb/tb_df_start_chan_fifo.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/df_start_chan_fifo.sv
// Start-token channel between two dataflow processes.
// The producer pushes a start token and the consumer pops it when it launches.
// Alongside the FIFO itself, the block exports the status that the deadlock
// detector reads:
//   - full/empty flags,
//   - per-end blocked flags,
//   - wrapping transaction counters,
//   - sticky overflow/underflow errors.
module df_start_chan_fifo #(
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned DATA_WIDTH = 1,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         if_write,
   input  logic [DATA_WIDTH-1:0]        if_din,
   output logic                         if_full_n,
   input  logic                         if_read,
   output logic [DATA_WIDTH-1:0]        if_dout,
   output logic                         if_empty_n,
   input  logic                         prod_waiting,
   input  logic                         cons_idle,
   output logic                         wr_blk,
   output logic                         rd_blk,
   output logic [CNT_WIDTH-1:0]         trans_in_cnt,
   output logic [CNT_WIDTH-1:0]         trans_out_cnt,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic                         err_overflow,
   output logic                         err_underflow
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   // Token storage and pointers
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;

   // Registered status
   logic                  full_n_q, full_n_d;
   logic                  empty_n_q, empty_n_d;
   logic [CNT_WIDTH-1:0]  cnt_in_q, cnt_in_d;
   logic [CNT_WIDTH-1:0]  cnt_out_q, cnt_out_d;
   logic                  err_ov_q, err_ov_d;
   logic                  err_un_q, err_un_d;

   // Handshake qualifiers and blocked-flag helper
   logic                  wr_en;
   logic                  rd_en;
   logic [CNT_WIDTH-1:0]  out_plus_occ;

   // Circular pointer advance; DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Accept qualifiers use the flags as registered, so a full channel rejects
   // a write even when a read frees a slot on the same edge.
   always_comb begin
      wr_en = if_write & full_n_q;
      rd_en = if_read & empty_n_q;

      wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;

      occ_d = occ_q;
      case ({wr_en, rd_en})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase

      full_n_d  = (occ_d != OCC_FULL);
      empty_n_d = (occ_d != '0);

      cnt_in_d  = cnt_in_q  + CNT_WIDTH'(wr_en);
      cnt_out_d = cnt_out_q + CNT_WIDTH'(rd_en);

      err_ov_d = err_ov_q | (if_write & ~full_n_q);
      err_un_d = err_un_q | (if_read  & ~empty_n_q);
   end

   // State update; reset wins over any same-cycle write or read.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         full_n_q  <= 1'b1;
         empty_n_q <= 1'b0;
         cnt_in_q  <= '0;
         cnt_out_q <= '0;
         err_ov_q  <= 1'b0;
         err_un_q  <= 1'b0;
      end else begin
         if (wr_en) begin
            mem_q[wr_ptr_q] <= if_din;
         end
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         occ_q     <= occ_d;
         full_n_q  <= full_n_d;
         empty_n_q <= empty_n_d;
         cnt_in_q  <= cnt_in_d;
         cnt_out_q <= cnt_out_d;
         err_ov_q  <= err_ov_d;
         err_un_q  <= err_un_d;
      end
   end

   // Blocked flags for the deadlock detector.
   // The counter term in wr_blk keeps the detector from acting on a
   // momentarily inconsistent snapshot.
   always_comb begin
      out_plus_occ = cnt_out_q + CNT_WIDTH'(occ_q);
      wr_blk = ~full_n_q & prod_waiting & ~if_read & (cnt_in_q == out_plus_occ);
      rd_blk = ~empty_n_q & cons_idle & ~if_write;
   end

   assign if_full_n     = full_n_q;
   assign if_empty_n    = empty_n_q;
   assign if_dout       = mem_q[rd_ptr_q];
   assign occupancy     = occ_q;
   assign trans_in_cnt  = cnt_in_q;
   assign trans_out_cnt = cnt_out_q;
   assign err_overflow  = err_ov_q;
   assign err_underflow = err_un_q;

   // Counters and occupancy must always agree modulo the counter width.
   a_cnt_invariant: assert property (@(posedge clock) disable iff (reset)
      ((cnt_in_q - cnt_out_q) == CNT_WIDTH'(occ_q)));

endmodule

// File: tb/tb_df_start_chan_fifo.sv
// Self-checking bench for df_start_chan_fifo: directed vector table, reset and
// counter-wrap sequences, then randomized traffic against a queue-based model.
module tb_df_start_chan_fifo;

   localparam int DEPTH = 2;
   localparam int DW    = 4;
   localparam int CW    = 16;
   localparam int OW    = $clog2(DEPTH + 1);

   logic          clock = 1'b0;
   logic          reset;
   logic          if_write;
   logic [DW-1:0] if_din;
   logic          if_full_n;
   logic          if_read;
   logic [DW-1:0] if_dout;
   logic          if_empty_n;
   logic          prod_waiting;
   logic          cons_idle;
   logic          wr_blk;
   logic          rd_blk;
   logic [CW-1:0] trans_in_cnt;
   logic [CW-1:0] trans_out_cnt;
   logic [OW-1:0] occupancy;
   logic          err_overflow;
   logic          err_underflow;

   always #5 clock = ~clock;

   df_start_chan_fifo #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .if_write      (if_write),
      .if_din        (if_din),
      .if_full_n     (if_full_n),
      .if_read       (if_read),
      .if_dout       (if_dout),
      .if_empty_n    (if_empty_n),
      .prod_waiting  (prod_waiting),
      .cons_idle     (cons_idle),
      .wr_blk        (wr_blk),
      .rd_blk        (rd_blk),
      .trans_in_cnt  (trans_in_cnt),
      .trans_out_cnt (trans_out_cnt),
      .occupancy     (occupancy),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a plain token queue plus counters and sticky errors.
   logic [DW-1:0] mq[$];
   int unsigned   m_cin;
   int unsigned   m_cout;
   bit            m_eov;
   bit            m_eun;

   typedef struct {
      bit          w;
      bit [DW-1:0] din;
      bit          r;
      bit          pw;
      bit          ci;
      bit          e_wb;
      bit          e_rb;
      int          e_occ;
      bit          e_fn;
      bit          e_en;
      bit [DW-1:0] e_dout;
      int          e_cin;
      int          e_cout;
      bit          e_eov;
      bit          e_eun;
   } vec_t;

   function automatic vec_t mk(int w, int d, int r, int pw, int ci, int wb, int rb,
                               int occ, int fn, int en, int dout, int cin, int cout,
                               int eov, int eun);
      vec_t v;
      v.w = 1'(w); v.din = DW'(d); v.r = 1'(r); v.pw = 1'(pw); v.ci = 1'(ci);
      v.e_wb = 1'(wb); v.e_rb = 1'(rb); v.e_occ = occ; v.e_fn = 1'(fn);
      v.e_en = 1'(en); v.e_dout = DW'(dout); v.e_cin = cin; v.e_cout = cout;
      v.e_eov = 1'(eov); v.e_eun = 1'(eun);
      return v;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      mq.delete();
      m_cin = 0; m_cout = 0; m_eov = 0; m_eun = 0;
   endtask

   function automatic bit exp_wb(bit pw, bit r);
      return (mq.size() == DEPTH) && pw && !r &&
             (((m_cin - m_cout) & 32'hFFFF) == mq.size());
   endfunction

   function automatic bit exp_rb(bit ci, bit w);
      return (mq.size() == 0) && ci && !w;
   endfunction

   task automatic model_step(input bit w, input logic [DW-1:0] d, input bit r);
      bit full  = (mq.size() == DEPTH);
      bit empty = (mq.size() == 0);
      if (w && full)  m_eov = 1;
      if (r && empty) m_eun = 1;
      if (r && !empty) begin
         void'(mq.pop_front());
         m_cout = (m_cout + 1) & 32'hFFFF;
      end
      if (w && !full) begin
         mq.push_back(d);
         m_cin = (m_cin + 1) & 32'hFFFF;
      end
   endtask

   // Apply one cycle: inputs after the previous edge, sample the combinational
   // blocked flags before the edge, return #1 after the edge.
   task automatic drive(input bit w, input logic [DW-1:0] d, input bit r,
                        input bit pw, input bit ci, output bit wb, output bit rb);
      if_write = w; if_din = d; if_read = r; prod_waiting = pw; cons_idle = ci;
      #1;
      wb = wr_blk;
      rb = rd_blk;
      model_step(w, d, r);
      @(posedge clock);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " occupancy"}, occupancy, mq.size());
      chk({tag, " if_full_n"}, if_full_n, mq.size() != DEPTH);
      chk({tag, " if_empty_n"}, if_empty_n, mq.size() != 0);
      if (mq.size() != 0) chk({tag, " if_dout"}, if_dout, mq[0]);
      chk({tag, " trans_in_cnt"}, trans_in_cnt, m_cin);
      chk({tag, " trans_out_cnt"}, trans_out_cnt, m_cout);
      chk({tag, " err_overflow"}, err_overflow, m_eov);
      chk({tag, " err_underflow"}, err_underflow, m_eun);
   endtask

   // Reset with a write and read pending; reset must win.
   task automatic do_reset(input string tag);
      if_write = 1; if_din = '1; if_read = 1; prod_waiting = 0; cons_idle = 0;
      reset = 1;
      @(posedge clock);
      #1;
      reset = 0;
      if_write = 0; if_read = 0;
      model_clear();
      chk({tag, " rst occupancy"}, occupancy, 0);
      chk({tag, " rst if_full_n"}, if_full_n, 1);
      chk({tag, " rst if_empty_n"}, if_empty_n, 0);
      chk({tag, " rst if_dout"}, if_dout, 0);
      chk({tag, " rst trans_in_cnt"}, trans_in_cnt, 0);
      chk({tag, " rst trans_out_cnt"}, trans_out_cnt, 0);
      chk({tag, " rst err_overflow"}, err_overflow, 0);
      chk({tag, " rst err_underflow"}, err_underflow, 0);
      #1;
      chk({tag, " rst wr_blk"}, wr_blk, 0);
      chk({tag, " rst rd_blk"}, rd_blk, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[11];
      bit   wb, rb, ewb, erb, w, r, pw, ci;
      logic [DW-1:0] d;

      reset = 1; if_write = 0; if_din = '0; if_read = 0; prod_waiting = 0; cons_idle = 0;
      @(posedge clock);
      @(posedge clock);
      #1;
      do_reset("init");

      //        w din r pw ci  wb rb  occ fn en dout cin cout eov eun
      tbl[0]  = mk(1, 1, 0, 0, 1,  0, 0,  1, 1, 1, 1,  1, 0, 0, 0);
      tbl[1]  = mk(1, 0, 0, 0, 1,  0, 0,  2, 0, 1, 1,  2, 0, 0, 0);
      tbl[2]  = mk(0, 0, 0, 1, 0,  1, 0,  2, 0, 1, 1,  2, 0, 0, 0);
      tbl[3]  = mk(0, 0, 1, 1, 0,  0, 0,  1, 1, 1, 0,  2, 1, 0, 0);
      tbl[4]  = mk(0, 0, 1, 0, 0,  0, 0,  0, 1, 0, 0,  2, 2, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 1,  0, 1,  0, 1, 0, 0,  2, 2, 0, 0);
      tbl[6]  = mk(0, 0, 1, 0, 1,  0, 1,  0, 1, 0, 0,  2, 2, 0, 1);
      tbl[7]  = mk(1, 1, 1, 0, 1,  0, 0,  1, 1, 1, 1,  3, 2, 0, 1);
      tbl[8]  = mk(1, 0, 1, 0, 0,  0, 0,  1, 1, 1, 0,  4, 3, 0, 1);
      tbl[9]  = mk(1, 1, 0, 0, 0,  0, 0,  2, 0, 1, 0,  5, 3, 0, 1);
      tbl[10] = mk(1, 0, 1, 1, 0,  0, 0,  1, 1, 1, 1,  5, 4, 1, 1);

      foreach (tbl[i]) begin
         drive(tbl[i].w, tbl[i].din, tbl[i].r, tbl[i].pw, tbl[i].ci, wb, rb);
         chk($sformatf("v%0d wr_blk", i), wb, tbl[i].e_wb);
         chk($sformatf("v%0d rd_blk", i), rb, tbl[i].e_rb);
         chk($sformatf("v%0d occupancy", i), occupancy, tbl[i].e_occ);
         chk($sformatf("v%0d if_full_n", i), if_full_n, tbl[i].e_fn);
         chk($sformatf("v%0d if_empty_n", i), if_empty_n, tbl[i].e_en);
         if (tbl[i].e_en) chk($sformatf("v%0d if_dout", i), if_dout, tbl[i].e_dout);
         chk($sformatf("v%0d trans_in_cnt", i), trans_in_cnt, tbl[i].e_cin);
         chk($sformatf("v%0d trans_out_cnt", i), trans_out_cnt, tbl[i].e_cout);
         chk($sformatf("v%0d err_overflow", i), err_overflow, tbl[i].e_eov);
         chk($sformatf("v%0d err_underflow", i), err_underflow, tbl[i].e_eun);
      end

      // Reset mid-operation: refill to full with errors set, then reset with a write pending.
      drive(1, 4'h5, 0, 0, 0, wb, rb);
      chk("midrst pre occupancy", occupancy, 2);
      chk("midrst pre err_overflow", err_overflow, 1);
      do_reset("midrst");

      // Counter wrap: prime one token, then 65536 write+read pairs, then drain.
      drive(1, 4'h5, 0, 0, 0, wb, rb);
      check_model("wrap prime");
      for (int k = 0; k < 65536; k++) begin
         drive(1, (k % 2 == 1) ? 4'h5 : 4'hA, 1, 0, 0, wb, rb);
         check_model("wrap");
      end
      drive(0, 4'h0, 1, 0, 0, wb, rb);
      chk("wrap trans_in_cnt", trans_in_cnt, 1);
      chk("wrap trans_out_cnt", trans_out_cnt, 1);
      chk("wrap occupancy", occupancy, 0);
      chk("wrap err_overflow", err_overflow, 0);
      chk("wrap err_underflow", err_underflow, 0);

      // Randomized traffic against the model, with occasional resets.
      do_reset("rand");
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset("rand");
         end else begin
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            pw = 1'($urandom_range(0, 1));
            ci = 1'($urandom_range(0, 1));
            d  = DW'($urandom);
            ewb = exp_wb(pw, r);
            erb = exp_rb(ci, w);
            drive(w, d, r, pw, ci, wb, rb);
            chk("rand wr_blk", wb, ewb);
            chk("rand rd_blk", rb, erb);
            check_model("rand");
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
